// File: rtl/pattern_seq_pkg.sv
// ============================================================================
// Module  : pattern_seq_pkg
// Brief   : Shared vector-word layout, sequencer states and constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pattern_seq_pkg;

    // Default field widths of the packed vector word {last, repeat, wft, wfc}
    localparam int DEF_WFT_W = 4;
    localparam int DEF_WFC_W = 184;
    localparam int DEF_RPT_W = 16;

    localparam int WFC_LSB  = 0;
    localparam int WFT_LSB  = WFC_LSB + DEF_WFC_W;
    localparam int RPT_LSB  = WFT_LSB + DEF_WFT_W;
    localparam int LAST_BIT = RPT_LSB + DEF_RPT_W;

    // Waveform character 0 means "no trigger" downstream
    localparam int WFC_NONE = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/tester_phase_gen.sv
// ============================================================================
// Module  : tester_phase_gen
// Brief   : Tester-cycle phase counter with tester_sync, wrap and prefetch strobes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tester_phase_gen #(
    parameter int PERIOD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tester_sync,
    output logic wrap,
    output logic pf_issue,
    output logic pf_capture
);

    localparam int              c_PH_W = $clog2(PERIOD);
    localparam logic [c_PH_W-1:0] c_LAST = c_PH_W'(PERIOD - 1);
    localparam logic [c_PH_W-1:0] c_HALF = c_PH_W'(PERIOD / 2);
    localparam logic [c_PH_W-1:0] c_ISSUE = c_PH_W'(1);
    localparam logic [c_PH_W-1:0] c_CAPT  = c_PH_W'(2);

    logic [c_PH_W-1:0] r_phase;

    // Phase rests at 0 outside RUN so the first RUN clock is always phase 0
    always_ff @(posedge clk) begin
        if (!rst_n || !en || (r_phase == c_LAST)) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + c_PH_W'(1);
        end
    end

    assign tester_sync = en && (r_phase >= c_HALF);
    assign wrap        = en && (r_phase == c_LAST);
    assign pf_issue    = en && (r_phase == c_ISSUE);
    assign pf_capture  = en && (r_phase == c_CAPT);

endmodule

`default_nettype wire

// File: rtl/pattern_vector_sequencer.sv
// ============================================================================
// Module  : pattern_vector_sequencer
// Brief   : Fetches packed vectors, applies repeats and drives tester_sync/wft/wfc.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_vector_sequencer
    import pattern_seq_pkg::*;
#(
    parameter int PERIOD = 8,
    parameter int ADDR_W = 12,
    parameter int WFT_W  = DEF_WFT_W,
    parameter int WFC_W  = DEF_WFC_W,
    parameter int RPT_W  = DEF_RPT_W,
    parameter int CNT_W  = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [ADDR_W-1:0]              start_addr,
    output logic                           mem_rd,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [1+RPT_W+WFT_W+WFC_W-1:0] mem_rdata,
    output logic                           tester_sync,
    output logic [WFT_W-1:0]               wft,
    output logic [WFC_W-1:0]               wfc,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [CNT_W-1:0]               cycle_cnt
);

    localparam int c_WORD_W   = 1 + RPT_W + WFT_W + WFC_W;
    localparam int c_WFT_LSB  = WFC_LSB + WFC_W;
    localparam int c_RPT_LSB  = c_WFT_LSB + WFT_W;
    localparam int c_LAST_BIT = c_RPT_LSB + RPT_W;

    seq_state_t          r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_cur_last;
    logic [RPT_W-1:0]    r_rpt_left;
    logic [WFT_W-1:0]    r_cur_wft;
    logic [WFC_W-1:0]    r_cur_wfc;
    logic                r_nxt_valid;
    logic [c_WORD_W-1:0] r_nxt_word;
    logic                r_err;
    logic [CNT_W-1:0]    r_cycle_cnt;

    logic w_run, w_sync, w_wrap, w_pf_issue, w_pf_capture, w_pf_ok;
    logic w_mem_rd;
    logic [ADDR_W-1:0] w_mem_addr;

    assign w_run   = (r_state == ST_RUN);
    assign w_pf_ok = !r_cur_last && (r_addr != {ADDR_W{1'b1}}) && !r_nxt_valid;

    tester_phase_gen #(
        .PERIOD (PERIOD)
    ) u_phase (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (w_run),
        .tester_sync (w_sync),
        .wrap        (w_wrap),
        .pf_issue    (w_pf_issue),
        .pf_capture  (w_pf_capture)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_rd    = 1'b0;
        w_mem_addr  = '0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) w_state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    w_mem_rd    = 1'b1;
                    w_mem_addr  = r_addr;
                    w_state_nxt = ST_PRIME;
                end
                ST_PRIME: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_pf_issue && w_pf_ok) begin
                        w_mem_rd   = 1'b1;
                        w_mem_addr = r_addr + ADDR_W'(1);
                    end
                    // Finish when repeats are used up and there is nothing to follow
                    if (w_wrap && (r_rpt_left == '0) && (r_cur_last || !r_nxt_valid)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_cur_last  <= 1'b0;
            r_rpt_left  <= '0;
            r_cur_wft   <= '0;
            r_cur_wfc   <= '0;
            r_nxt_valid <= 1'b0;
            r_nxt_word  <= '0;
            r_err       <= 1'b0;
            r_cycle_cnt <= '0;
        end else if (abort) begin
            r_nxt_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr      <= start_addr;
                        r_err       <= 1'b0;
                        r_cycle_cnt <= '0;
                        r_nxt_valid <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    r_cur_last <= mem_rdata[c_LAST_BIT];
                    r_rpt_left <= mem_rdata[c_RPT_LSB +: RPT_W];
                    r_cur_wft  <= mem_rdata[c_WFT_LSB +: WFT_W];
                    r_cur_wfc  <= mem_rdata[WFC_LSB +: WFC_W];
                end
                ST_RUN: begin
                    // Prefetch conditions are unchanged between issue and capture phases
                    if (w_pf_capture && w_pf_ok) begin
                        r_nxt_word  <= mem_rdata;
                        r_nxt_valid <= 1'b1;
                        r_addr      <= r_addr + ADDR_W'(1);
                    end
                    if (w_wrap) begin
                        if (r_cycle_cnt != {CNT_W{1'b1}}) begin
                            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                        end
                        if (r_rpt_left != '0) begin
                            r_rpt_left <= r_rpt_left - RPT_W'(1);
                        end else if (r_cur_last) begin
                            r_rpt_left <= '0;
                        end else if (!r_nxt_valid) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cur_last  <= r_nxt_word[c_LAST_BIT];
                            r_rpt_left  <= r_nxt_word[c_RPT_LSB +: RPT_W];
                            r_cur_wft   <= r_nxt_word[c_WFT_LSB +: WFT_W];
                            r_cur_wfc   <= r_nxt_word[WFC_LSB +: WFC_W];
                            r_nxt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_nxt_valid <= r_nxt_valid;
                end
            endcase
        end
    end

    assign mem_rd      = w_mem_rd;
    assign mem_addr    = w_mem_addr;
    assign tester_sync = w_sync;
    assign wft         = w_run ? r_cur_wft : '0;
    assign wfc         = w_run ? r_cur_wfc : WFC_W'(WFC_NONE);
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE) && !r_err;
    assign err         = r_err;
    assign cycle_cnt   = r_cycle_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pattern_vector_sequencer.sv
// ============================================================================
// Module  : tb_pattern_vector_sequencer
// Brief   : Directed self-checking bench for pattern_vector_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pattern_vector_sequencer;

    localparam int ADDR_W = 12;
    localparam int WFT_W  = 4;
    localparam int WFC_W  = 184;
    localparam int RPT_W  = 16;
    localparam int CNT_W  = 32;
    localparam int WORD_W = 1 + RPT_W + WFT_W + WFC_W;

    logic               clk = 1'b0;
    logic               rst_n, start, abort;
    logic [ADDR_W-1:0]  start_addr;
    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic [WORD_W-1:0]  mem_rdata = '0;
    logic               tester_sync;
    logic [WFT_W-1:0]   wft;
    logic [WFC_W-1:0]   wfc;
    logic               busy, done, err;
    logic [CNT_W-1:0]   cycle_cnt;

    logic [WORD_W-1:0]  mem [0:4095];

    int n_total = 0;
    int n_bad   = 0;

    // Monitor counters
    int n_rise, n_done, n_rd, n_rd0, n_wfc_bad;
    logic prev_sync = 1'b0;
    logic [WFC_W-1:0] prev_wfc = '0;
    int rd_q[$];
    int wft_q[$];

    always #5 clk = ~clk;

    pattern_vector_sequencer #(
        .PERIOD (8), .ADDR_W (ADDR_W), .WFT_W (WFT_W),
        .WFC_W (WFC_W), .RPT_W (RPT_W), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
        .start_addr (start_addr), .mem_rd (mem_rd), .mem_addr (mem_addr),
        .mem_rdata (mem_rdata), .tester_sync (tester_sync), .wft (wft),
        .wfc (wfc), .busy (busy), .done (done), .err (err), .cycle_cnt (cycle_cnt)
    );

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (tester_sync && !prev_sync) begin
            n_rise++;
            wft_q.push_back(int'(wft));
        end
        if (done) n_done++;
        if (mem_rd) begin
            n_rd++;
            rd_q.push_back(int'(mem_addr));
            if (mem_addr == '0) n_rd0++;
        end
        // wfc between two vectors may only move on a tester_sync falling edge
        if ((wfc != prev_wfc) && (wfc != '0) && (prev_wfc != '0) && !(prev_sync && !tester_sync))
            n_wfc_bad++;
        prev_sync = tester_sync;
        prev_wfc  = wfc;
    end

    function automatic logic [WORD_W-1:0] mk(input logic last, input logic [RPT_W-1:0] rpt,
                                             input logic [WFT_W-1:0] t, input logic [WFC_W-1:0] c);
        return {last, rpt, t, c};
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        n_rise = 0; n_done = 0; n_rd = 0; n_rd0 = 0; n_wfc_bad = 0;
        rd_q.delete(); wft_q.delete();
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] a);
        start_addr = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_rise(input int budget);
        int n = 0;
        logic prev;
        prev = tester_sync;
        @(negedge clk);
        while (!(tester_sync && !prev) && n < budget) begin
            prev = tester_sync;
            @(negedge clk);
            n++;
        end
        chk("rise_timeout", tester_sync, 1'b1);
    endtask

    initial begin
        int exp_wft [6] = '{3, 3, 3, 5, 9, 9};
        int exp_rd  [3] = '{5, 6, 7};
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_addr = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[0]    = mk(1'b1, 16'd0, 4'd0, 184'h1);
        mem[5]    = mk(1'b0, 16'd2, 4'd3, 184'hA5);
        mem[6]    = mk(1'b0, 16'd0, 4'd5, 184'h5A00);
        mem[7]    = mk(1'b1, 16'd1, 4'd9, 184'h33_0000);
        mem[10]   = mk(1'b0, 16'd0, 4'd1, 184'h11);
        mem[11]   = mk(1'b1, 16'd0, 4'd2, 184'h22);
        mem[4095] = mk(1'b0, 16'd0, 4'd7, 184'h77);
        repeat (3) @(negedge clk);

        chk("rst_sync", tester_sync, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wfc", wfc, '0);
        chk("rst_cnt", cycle_cnt, '0);
        chk("rst_memrd", mem_rd, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single last vector: exact per-clock timing
        clr_mon();
        pulse_start(12'd0);
        chk("t1_fetch_rd", mem_rd, 1'b1);
        chk("t1_fetch_addr", mem_addr, 12'd0);
        chk("t1_busy", busy, 1'b1);
        @(negedge clk);
        chk("t1_prime_rd", mem_rd, 1'b0);
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            chk($sformatf("t1_sync_p%0d", p), tester_sync, (p >= 4) ? 1'b1 : 1'b0);
            chk($sformatf("t1_wfc_p%0d", p), wfc, 184'h1);
        end
        @(negedge clk);
        chk("t1_done", done, 1'b1);
        chk("t1_done_wfc", wfc, '0);
        chk("t1_done_sync", tester_sync, 1'b0);
        @(negedge clk);
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_idle_done", done, 1'b0);
        chk("t1_cnt", cycle_cnt, 32'd1);
        chk("t1_ndone", n_done, 1);
        chk("t1_nrise", n_rise, 1);

        // Three vectors with repeats 2,0,1
        clr_mon();
        pulse_start(12'd5);
        wait_idle(200);
        chk("t2_nrise", n_rise, 6);
        chk("t2_cnt", cycle_cnt, 32'd6);
        chk("t2_nrd", n_rd, 3);
        chk("t2_ndone", n_done, 1);
        chk("t2_err", err, 1'b0);
        chk("t2_wfc_change", n_wfc_bad, 0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t2_rd%0d", i), (i < rd_q.size()) ? rd_q[i] : -1, exp_rd[i]);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t2_wft%0d", i), (i < wft_q.size()) ? wft_q[i] : -1, exp_wft[i]);

        // Abort at RUN phase 5 of the second vector
        clr_mon();
        pulse_start(12'd10);
        wait_rise(50);
        wait_rise(50);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t3_busy", busy, 1'b0);
        chk("t3_sync", tester_sync, 1'b0);
        chk("t3_wfc", wfc, '0);
        chk("t3_wft", wft, '0);
        repeat (4) @(negedge clk);
        chk("t3_cnt", cycle_cnt, 32'd1);
        chk("t3_ndone", n_done, 0);
        chk("t3_err", err, 1'b0);

        // Top of address space without a last vector
        clr_mon();
        pulse_start(12'd4095);
        wait_idle(200);
        chk("t4_err", err, 1'b1);
        chk("t4_ndone", n_done, 0);
        chk("t4_nrise", n_rise, 1);
        chk("t4_cnt", cycle_cnt, 32'd1);
        chk("t4_rd0", n_rd0, 0);
        chk("t4_nrd", n_rd, 1);
        clr_mon();
        pulse_start(12'd0);
        chk("t4_err_clr", err, 1'b0);
        wait_idle(200);
        chk("t4_ndone2", n_done, 1);

        // start held high across completion
        clr_mon();
        start_addr = 12'd0;
        start = 1'b1;
        begin
            int n = 0;
            while (!done && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t5_done_seen", done, 1'b1);
        chk("t5_nrd_first", n_rd, 1);
        @(negedge clk);
        chk("t5_idle_gap", busy, 1'b0);
        @(negedge clk);
        chk("t5_restart_busy", busy, 1'b1);
        chk("t5_restart_rd", mem_rd, 1'b1);
        start = 1'b0;
        wait_idle(200);
        chk("t5_ndone", n_done, 2);
        chk("t5_nrd", n_rd, 2);

        // Reset at RUN phase 6, then a normal run
        clr_mon();
        pulse_start(12'd5);
        wait_rise(50);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_sync", tester_sync, 1'b0);
        chk("t6_wft", wft, '0);
        chk("t6_wfc", wfc, '0);
        chk("t6_memrd", mem_rd, 1'b0);
        chk("t6_memaddr", mem_addr, '0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_err", err, 1'b0);
        chk("t6_cnt", cycle_cnt, '0);
        clr_mon();
        pulse_start(12'd0);
        wait_idle(200);
        chk("t6_ndone", n_done, 1);
        chk("t6_cnt_after", cycle_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
